// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared digit types and step encoding for the calculator datapath
package calc_pkg;

    localparam int DIGIT_W  = 4;
    localparam int DEC_BASE = 10;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [2:0] {
        NONE,
        UP,
        DOWN,
        LOAD,
        CLR
    } step_e;

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one modulo-BASE digit with registered top/bottom indicators
module bcd_digit_cell
    import calc_pkg::*;
#(
    parameter int W    = DIGIT_W,
    parameter int BASE = DEC_BASE
) (
    input  logic         clk,
    input  logic         rst,
    input  step_e        step,
    input  logic         carry_in,
    input  logic         borrow_in,
    input  logic [W-1:0] load_field,
    output logic [W-1:0] digit,
    output logic         at_top,
    output logic         at_bottom
);

    localparam logic [W-1:0] TOP = W'(BASE - 1);

    logic [W-1:0] nxt;

    always_comb begin
        nxt = digit;
        case (step)
            CLR:  nxt = '0;
            LOAD: nxt = (int'(load_field) >= BASE) ? TOP : load_field;
            UP: begin
                if (carry_in) nxt = (digit == TOP) ? '0 : digit + W'(1);
            end
            DOWN: begin
                if (borrow_in) nxt = (digit == '0) ? TOP : digit - W'(1);
            end
            default: nxt = digit;
        endcase
    end

    // Indicators are registered from the next value so they line up with digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit     <= '0;
            at_top    <= 1'b0;
            at_bottom <= 1'b1;
        end else begin
            digit     <= nxt;
            at_top    <= (nxt == TOP);
            at_bottom <= (nxt == '0);
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit modulo-BASE up/down counter with load, clear and boundary flags
module bcd_updown_counter
    import calc_pkg::*;
#(
    parameter int W        = DIGIT_W,
    parameter int DIGITS   = 4,
    parameter int BASE     = DEC_BASE,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    input  logic                clr,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_val,
    output logic [DIGITS*W-1:0] count,
    output logic                ovf,
    output logic                unf,
    output logic                at_max,
    output logic                at_zero
);

    logic              inc_q, dec_q;
    logic              inc_p, dec_p;
    logic              all_top, all_bot;
    logic              sat_hold;
    step_e             step, cell_step;
    logic [DIGITS-1:0] at_top, at_bottom;

    assign inc_p   = inc & ~inc_q;
    assign dec_p   = dec & ~dec_q;
    assign all_top = &at_top;
    assign all_bot = &at_bottom;

    always_comb begin
        step = NONE;
        if (clr)                  step = CLR;
        else if (load)            step = LOAD;
        else if (inc_p && !dec_p) step = UP;
        else if (dec_p && !inc_p) step = DOWN;
    end

    // In saturate mode a boundary step is turned into a no-op for the cells.
    assign sat_hold  = (SATURATE != 0) &&
                       (((step == UP) && all_top) || ((step == DOWN) && all_bot));
    assign cell_step = sat_hold ? NONE : step;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic carry_in, borrow_in;

        if (i == 0) begin : g_first
            assign carry_in  = 1'b1;
            assign borrow_in = 1'b1;
        end else begin : g_chain
            assign carry_in  = &at_top[i-1:0];
            assign borrow_in = &at_bottom[i-1:0];
        end

        bcd_digit_cell #(
            .W    (W),
            .BASE (BASE)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .step       (cell_step),
            .carry_in   (carry_in),
            .borrow_in  (borrow_in),
            .load_field (load_val[i*W +: W]),
            .digit      (count[i*W +: W]),
            .at_top     (at_top[i]),
            .at_bottom  (at_bottom[i])
        );
    end

    // Edge registers reset high so a button held through reset is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q <= 1'b1;
            dec_q <= 1'b1;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            inc_q <= inc;
            dec_q <= dec;
            ovf   <= (step == UP) && all_top;
            unf   <= (step == DOWN) && all_bot;
        end
    end

    assign at_max  = all_top;
    assign at_zero = all_bot;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for wrap and saturate counter variants
module tb_bcd_updown_counter;

    localparam int W      = 4;
    localparam int DIGITS = 4;
    localparam int BASE   = 10;
    localparam int MAXV   = BASE ** DIGITS - 1;

    logic                clk = 1'b0;
    logic                rst, inc, dec, clr, load;
    logic [DIGITS*W-1:0] load_val;
    logic [DIGITS*W-1:0] count0, count1;
    logic                ovf0, unf0, at_max0, at_zero0;
    logic                ovf1, unf1, at_max1, at_zero1;

    int n_checks = 0;
    int n_pass   = 0;

    int mv[2];
    bit m_ovf[2];
    bit m_unf[2];
    bit m_pinc, m_pdec;

    always #5 clk = ~clk;

    bcd_updown_counter #(.W(W), .DIGITS(DIGITS), .BASE(BASE), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .load(load),
        .load_val(load_val), .count(count0), .ovf(ovf0), .unf(unf0),
        .at_max(at_max0), .at_zero(at_zero0)
    );

    bcd_updown_counter #(.W(W), .DIGITS(DIGITS), .BASE(BASE), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .load(load),
        .load_val(load_val), .count(count1), .ovf(ovf1), .unf(unf1),
        .at_max(at_max1), .at_zero(at_zero1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DIGITS*W-1:0] to_packed(input int v);
        logic [DIGITS*W-1:0] p;
        p = '0;
        for (int i = 0; i < DIGITS; i++) begin
            p[i*W +: W] = W'(v % BASE);
            v = v / BASE;
        end
        return p;
    endfunction

    function automatic int clamp_value(input logic [DIGITS*W-1:0] lv);
        int v, mult, f;
        v = 0;
        mult = 1;
        for (int i = 0; i < DIGITS; i++) begin
            f = int'(lv[i*W +: W]);
            if (f >= BASE) f = BASE - 1;
            v += f * mult;
            mult *= BASE;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mv[s] = 0;
            m_ovf[s] = 1'b0;
            m_unf[s] = 1'b0;
        end
        m_pinc = 1'b1;
        m_pdec = 1'b1;
    endtask

    task automatic model_edge();
        bit up, dn;
        up = inc && !m_pinc && !(dec && !m_pdec);
        dn = dec && !m_pdec && !(inc && !m_pinc);
        for (int s = 0; s < 2; s++) begin
            m_ovf[s] = 1'b0;
            m_unf[s] = 1'b0;
            if (clr) mv[s] = 0;
            else if (load) mv[s] = clamp_value(load_val);
            else if (up) begin
                if (mv[s] == MAXV) begin
                    m_ovf[s] = 1'b1;
                    if (s == 0) mv[s] = 0;
                end else mv[s]++;
            end else if (dn) begin
                if (mv[s] == 0) begin
                    m_unf[s] = 1'b1;
                    if (s == 0) mv[s] = MAXV;
                end else mv[s]--;
            end
        end
        m_pinc = inc;
        m_pdec = dec;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count0"},   32'(count0),   32'(to_packed(mv[0])));
        check({tag, ".ovf0"},     32'(ovf0),     32'(m_ovf[0]));
        check({tag, ".unf0"},     32'(unf0),     32'(m_unf[0]));
        check({tag, ".at_max0"},  32'(at_max0),  32'(mv[0] == MAXV));
        check({tag, ".at_zero0"}, 32'(at_zero0), 32'(mv[0] == 0));
        check({tag, ".count1"},   32'(count1),   32'(to_packed(mv[1])));
        check({tag, ".ovf1"},     32'(ovf1),     32'(m_ovf[1]));
        check({tag, ".unf1"},     32'(unf1),     32'(m_unf[1]));
        check({tag, ".at_max1"},  32'(at_max1),  32'(mv[1] == MAXV));
        check({tag, ".at_zero1"}, 32'(at_zero1), 32'(mv[1] == 0));
    endtask

    task automatic cycle(input string tag);
        if (rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic i, input logic d, input logic c, input logic l,
                          input logic [DIGITS*W-1:0] lv);
        inc = i;
        dec = d;
        clr = c;
        load = l;
        load_val = lv;
    endtask

    initial begin
        rst = 1'b0;
        set_in(1, 0, 0, 0, '0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        cycle("rst_hold");
        cycle("rst_hold");
        rst = 1'b0;
        for (int k = 0; k < 5; k++) cycle("inc_held");
        check("inc_held_direct", 32'(count0), 32'h0000);
        set_in(0, 0, 0, 0, '0);
        cycle("inc_low");
        set_in(1, 0, 0, 0, '0);
        cycle("inc_edge");
        check("first_inc_direct", 32'(count0), 32'h0001);

        set_in(0, 0, 0, 1, 16'h0199);
        cycle("load_0199");
        set_in(1, 0, 0, 0, 16'h0199);
        cycle("carry_0200");
        check("carry_direct", 32'(count0), 32'h0200);

        set_in(0, 0, 0, 1, 16'h9999);
        cycle("load_9999");
        set_in(1, 0, 0, 0, 16'h9999);
        cycle("ovf_edge");
        check("wrap_direct", 32'({ovf0, count0}), 32'h10000);
        check("sat_hold_direct", 32'({ovf1, count1}), 32'h19999);
        set_in(0, 0, 0, 0, '0);
        cycle("ovf_drop");
        set_in(0, 1, 0, 0, '0);
        cycle("unf_wrap");
        check("unf_wrap_direct", 32'({unf0, count0}), 32'h19999);

        set_in(0, 0, 0, 1, 16'h0000);
        cycle("load_0000");
        set_in(0, 1, 0, 0, 16'h0000);
        cycle("unf_sat");
        check("unf_sat_direct", 32'({unf1, count1}), 32'h10000);
        set_in(0, 0, 0, 0, '0);
        cycle("unf_drop");

        set_in(0, 0, 0, 1, 16'h0C34);
        cycle("load_clamp");
        check("clamp_direct", 32'(count0), 32'h0934);
        set_in(1, 1, 0, 0, '0);
        cycle("inc_dec_same");
        check("inc_dec_direct", 32'(count0), 32'h0934);
        set_in(0, 0, 0, 0, '0);
        cycle("idle");
        set_in(1, 0, 1, 0, '0);
        cycle("clr_wins");
        check("clr_direct", 32'(count0), 32'h0000);
        set_in(0, 0, 1, 1, 16'h5555);
        cycle("clr_over_load");

        set_in(0, 0, 0, 1, 16'h0457);
        cycle("load_0457");
        set_in(0, 0, 0, 0, '0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        cycle("async_rst_hold");
        rst = 1'b0;

        for (int k = 0; k < 400; k++) begin
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
            load = ($urandom_range(0, 7) == 0);
            load_val = 16'($urandom);
            if ($urandom_range(0, 2) == 0)
                load_val = $urandom_range(0, 1) ? 16'h9999 : 16'h0000;
            cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
